mac_accum_mc: RTL

Multi-channel, time-interleaved signed multiply-accumulate engine. It is the parametrised successor of the single-channel MAC. Each accepted sample pair is multiplied and added into the accumulator of the current channel. Channels are served round-robin. After ACC_LEN products per channel, the block emits a rounded, saturated WIDTH-bit result through a valid/ready output register. It sits between the sample front-end and the filter/decimation output stage.

---
 rtl/mac_accum_mc.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/mac_accum_mc.sv
// mac_accum_mc
//   Multi-channel, time-interleaved signed multiply-accumulate engine.
//   Sample pairs arrive round-robin ch0..ch(NUM_CH-1). Each accepted pair is
//   multiplied and added into its channel's accumulator. After ACC_LEN
//   products on a channel, the block rounds the sum (half toward +inf),
//   shifts it right by SHIFT, saturates it to WIDTH bits and loads it into a
//   valid/ready output register.
//
// Ports
//   Clk_CI       clock, rising edge
//   Rst_RI       synchronous reset, active high (beats everything)
//   Clr_SI       synchronous restart: accumulators, counters, overflow flag
//   InValid_SI   input sample pair valid
//   InReady_SO   block can accept a sample this cycle
//   In0_DI       signed operand A
//   In1_DI       signed operand B
//   OutValid_SO  result register holds a result
//   OutReady_SI  downstream accepts the result
//   Out_DO       signed rounded/saturated result
//   OutCh_DO     channel index of Out_DO
//   Ovf_SO       sticky: some emitted result saturated

module mac_accum_mc #(
    parameter int WIDTH   = 12,
    parameter int NUM_CH  = 4,
    parameter int ACC_LEN = 16,
    parameter int SHIFT   = 11,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic             Clk_CI,
    input  logic             Rst_RI,
    input  logic             Clr_SI,
    input  logic             InValid_SI,
    output logic             InReady_SO,
    input  logic [WIDTH-1:0] In0_DI,
    input  logic [WIDTH-1:0] In1_DI,
    output logic             OutValid_SO,
    input  logic             OutReady_SI,
    output logic [WIDTH-1:0] Out_DO,
    output logic [CH_W-1:0]  OutCh_DO,
    output logic             Ovf_SO
);

    localparam int ACC_W   = 2 * WIDTH + $clog2(ACC_LEN);
    localparam int SMP_W   = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int RND_POS = (SHIFT > 0) ? SHIFT - 1 : 0;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(NUM_CH - 1);
    localparam logic [SMP_W-1:0] LAST_SMP = SMP_W'(ACC_LEN - 1);

    // Rounding offset 2^(SHIFT-1); zero when no shift is applied.
    localparam logic signed [ACC_W:0] RND_ADD =
        (SHIFT > 0) ? ((ACC_W + 1)'(1) << RND_POS) : '0;

    // Saturation limits expressed at the widened rounding width.
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - WIDTH){1'b0}}, {(WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - WIDTH){1'b1}}, {(WIDTH - 1){1'b0}}};

    // State
    logic signed [ACC_W-1:0] acc_q [NUM_CH];
    logic signed [ACC_W-1:0] acc_d [NUM_CH];
    logic [CH_W-1:0]         ch_cnt_q,    ch_cnt_d;
    logic [SMP_W-1:0]        smp_cnt_q,   smp_cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [WIDTH-1:0]        out_q,       out_d;
    logic [CH_W-1:0]         out_ch_q,    out_ch_d;
    logic                    ovf_q,       ovf_d;

    // Datapath
    logic                    in_ready;
    logic                    accept;
    logic                    last;
    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0] acc_base;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W:0]   rnd_sum;
    logic signed [ACC_W:0]   shifted;
    logic signed [ACC_W:0]   clipped;
    logic                    sat_hi;
    logic                    sat_lo;

    always_comb begin
        // Only a result that cannot drain this cycle blocks the input.
        in_ready = !(out_valid_q && !OutReady_SI);
        accept   = InValid_SI && in_ready && !Clr_SI;
        last     = (smp_cnt_q == LAST_SMP);

        prod     = (2 * WIDTH)'($signed(In0_DI)) * (2 * WIDTH)'($signed(In1_DI));

        // First product of a block overwrites the stale accumulator value.
        // With ACC_LEN==1 the sample counter is always zero, so the base is 0.
        acc_base = (smp_cnt_q == '0) ? '0 : acc_q[ch_cnt_q];
        acc_sum  = acc_base + ACC_W'(prod);

        rnd_sum  = (ACC_W + 1)'(acc_sum) + RND_ADD;
        shifted  = rnd_sum >>> SHIFT;

        sat_hi   = (shifted > SAT_MAX);
        sat_lo   = (shifted < SAT_MIN);
        if (sat_hi) begin
            clipped = SAT_MAX;
        end else if (sat_lo) begin
            clipped = SAT_MIN;
        end else begin
            clipped = shifted;
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            acc_d[i] = Clr_SI ? '0 : acc_q[i];
        end
        ch_cnt_d    = ch_cnt_q;
        smp_cnt_d   = smp_cnt_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        out_ch_d    = out_ch_q;
        ovf_d       = ovf_q;

        if (Clr_SI) begin
            ch_cnt_d  = '0;
            smp_cnt_d = '0;
            ovf_d     = 1'b0;
        end else if (accept) begin
            acc_d[ch_cnt_q] = acc_sum;
            if (ch_cnt_q == LAST_CH) begin
                ch_cnt_d  = '0;
                smp_cnt_d = last ? '0 : smp_cnt_q + 1'b1;
            end else begin
                ch_cnt_d  = ch_cnt_q + 1'b1;
            end
        end

        // A load wins over a drain, so a simultaneous drain+load stays valid.
        if (accept && last) begin
            out_valid_d = 1'b1;
            out_d       = clipped[WIDTH-1:0];
            out_ch_d    = ch_cnt_q;
            if (sat_hi || sat_lo) begin
                ovf_d = 1'b1;
            end
        end else if (out_valid_q && OutReady_SI) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
            ch_cnt_q    <= '0;
            smp_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_ch_q    <= '0;
            ovf_q       <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            ch_cnt_q    <= ch_cnt_d;
            smp_cnt_q   <= smp_cnt_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            out_ch_q    <= out_ch_d;
            ovf_q       <= ovf_d;
        end
    end

    assign InReady_SO  = in_ready;
    assign OutValid_SO = out_valid_q;
    assign Out_DO      = out_q;
    assign OutCh_DO    = out_ch_q;
    assign Ovf_SO      = ovf_q;

endmodule
